// File: rtl/mdu_exec.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One operation at a time; stalls the pipeline until a one-cycle result pulse.
module mdu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mextE,
  input  logic [2:0]       funct3E,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             flushE,
  output logic [WIDTH-1:0] mduresultE,
  output logic             mduvalidE,
  output logic             stallmduE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   mag_a_reg;
  logic [WIDTH-1:0]   mag_b_reg;
  logic               neg_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH:0]     rem_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               valid_reg;

  // Accept-time decode
  logic             is_div;
  logic             signed_a;
  logic             signed_b;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_next;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] special_result;

  always_comb begin
    is_div   = funct3E[2];
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (funct3E)
      3'b001, 3'b100, 3'b110: begin signed_a = 1'b1; signed_b = 1'b1; end
      3'b010:                 signed_a = 1'b1;
      default: ;
    endcase
    sign_a   = signed_a & srcAE[WIDTH-1];
    sign_b   = signed_b & srcBE[WIDTH-1];
    mag_a    = sign_a ? -srcAE : srcAE;
    mag_b    = sign_b ? -srcBE : srcBE;
    // REM follows the dividend's sign; every other signed op uses the XOR
    neg_next = (funct3E == 3'b110) ? sign_a : (sign_a ^ sign_b);
    div_zero = is_div && (srcBE == '0);
    div_ovf  = is_div && !funct3E[0] && (srcAE == MIN_VAL) && (srcBE == ALL_ONES);
    special_result = '0;
    if (div_zero)
      special_result = funct3E[1] ? srcAE : ALL_ONES;
    else if (div_ovf)
      special_result = funct3E[1] ? '0 : MIN_VAL;
  end

  // One shift-add step: multiplier sits in the low half and shifts out as the
  // partial product shifts in from the top.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_result;

  always_comb begin
    mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? mag_a_reg : '0)};
    mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    mul_prod     = neg_reg ? -mul_acc_next : mul_acc_next;
    mul_result   = (op_reg == 3'b000) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];
  end

  // One restoring-division step: dividend shifts out of acc_reg's low half,
  // quotient bits shift in behind it.
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [WIDTH:0]   div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  logic [WIDTH-1:0] div_result;

  always_comb begin
    div_shift    = {rem_reg, acc_reg[WIDTH-1]};
    div_diff     = div_shift - {2'b00, mag_b_reg};
    div_ge       = ~div_diff[WIDTH+1];
    div_rem_next = div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
    div_quo_next = {acc_reg[WIDTH-2:0], div_ge};
    if (op_reg[1])
      div_result = neg_reg ? -div_rem_next[WIDTH-1:0] : div_rem_next[WIDTH-1:0];
    else
      div_result = neg_reg ? -div_quo_next : div_quo_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else if (flushE) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          valid_reg <= 1'b0;
          if (mextE) begin
            op_reg    <= funct3E;
            mag_a_reg <= mag_a;
            mag_b_reg <= mag_b;
            neg_reg   <= neg_next;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            acc_reg   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            if (div_zero || div_ovf) begin
              result_reg <= special_result;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (op_reg[2]) begin
            acc_reg[WIDTH-1:0] <= div_quo_next;
            rem_reg            <= div_rem_next;
          end else begin
            acc_reg <= mul_acc_next;
          end
          if (cnt_reg == LAST) begin
            result_reg <= op_reg[2] ? div_result : mul_result;
            valid_reg  <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          // The same instruction is still in EX here; never re-accept it.
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mduresultE = result_reg;
  assign mduvalidE  = valid_reg;
  assign stallmduE  = ((state_reg == IDLE) && mextE && !flushE) || (state_reg == CALC);

endmodule
